load_align_unit: RTL

- Sequential load-return stage between the data-memory bus and the M/W pipeline boundary.
- Accepts one load request, issues a word-aligned bus read, and waits a variable number of cycles for return data.
- Extracts and sign- or zero-extends the addressed byte, half, word or dword lane, then holds the result until the consumer accepts it.
- Generalises the old combinational byte/half/word extender: parametrised width, unsigned loads, misalignment and bus-timeout exceptions, and a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/load_extract.sv | 52 +++++
 rtl/load_align_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load-return path: width codes, exception codes
// and the controller state type.
package lsu_pkg;

   localparam logic [1:0] W_WORD  = 2'd0;
   localparam logic [1:0] W_HALF  = 2'd1;
   localparam logic [1:0] W_BYTE  = 2'd2;
   localparam logic [1:0] W_DWORD = 2'd3;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_DBE  = 5'd7;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } lsu_state_t;

endpackage

// File: rtl/load_extract.sv
// Combinational lane selector and sign/zero extender for returned bus data.
// The addressed lane is shifted down to bit 0, masked to the access width,
// and the upper bits are filled with the lane MSB or with zeros.
module load_extract
   import lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]            rdata,
   input  logic [$clog2(DATA_W/8)-1:0]  off,
   input  logic [1:0]                   width,
   input  logic                         is_unsigned,
   output logic [DATA_W-1:0]            value
);

   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] lane_mask;
   logic              lane_msb;

   // Shift the addressed lane to the bottom, then mask and extend it.
   always_comb begin
      shifted   = rdata >> {off, 3'b000};
      lane_mask = '1;
      lane_msb  = 1'b0;
      value     = rdata;
      case (width)
         W_BYTE: begin
            lane_mask = DATA_W'(8'hFF);
            lane_msb  = shifted[7];
         end
         W_HALF: begin
            lane_mask = DATA_W'(16'hFFFF);
            lane_msb  = shifted[15];
         end
         W_WORD: begin
            lane_mask = DATA_W'(32'hFFFF_FFFF);
            lane_msb  = shifted[31];
         end
         default: begin
            lane_mask = '1;
            lane_msb  = 1'b0;
         end
      endcase
      if (width != W_DWORD) begin
         value = shifted & lane_mask;
         if (!is_unsigned && lane_msb) begin
            value = value | ~lane_mask;
         end
      end
   end

endmodule

// File: rtl/load_align_unit.sv
// Load-return stage: accepts one load, issues an aligned bus read, waits for
// the data (or times out), extends the addressed lane and holds the result
// until the consumer takes it. All outputs are registered.
module load_align_unit
   import lsu_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_width,
   input  logic              req_unsigned,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [4:0]        resp_exc
);

   localparam int OFF_W = $clog2(DATA_W / 8);
   localparam int CNT_W = $clog2(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   lsu_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        lat_width;
   logic [OFF_W-1:0]  lat_off;
   logic              lat_uns;
   logic              misaligned;
   logic [ADDR_W-1:0] aligned_addr;
   logic [DATA_W-1:0] extracted;

   // Decide whether the incoming request is illegal for its width or bus size.
   always_comb begin
      misaligned = 1'b0;
      case (req_width)
         W_HALF:  misaligned = req_addr[0];
         W_WORD:  misaligned = |req_addr[1:0];
         W_DWORD: misaligned = (DATA_W == 32) || (|req_addr[2:0]);
         default: misaligned = 1'b0;
      endcase
   end

   assign aligned_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   load_extract #(
      .DATA_W(DATA_W)
   ) u_extract (
      .rdata      (mem_rdata),
      .off        (lat_off),
      .width      (lat_width),
      .is_unsigned(lat_uns),
      .value      (extracted)
   );

   // Controller: accept, wait for bus data or timeout, hold the response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_width  <= W_WORD;
         lat_off    <= '0;
         lat_uns    <= 1'b0;
         req_ready  <= 1'b1;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_exc   <= EXC_NONE;
      end else if (flush) begin
         state      <= IDLE;
         cnt        <= '0;
         req_ready  <= 1'b1;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_exc   <= EXC_NONE;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_width <= req_width;
                  lat_off   <= req_addr[OFF_W-1:0];
                  lat_uns   <= req_unsigned;
                  req_ready <= 1'b0;
                  if (misaligned) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_data  <= '0;
                     resp_exc   <= EXC_ADEL;
                  end else begin
                     state    <= WAIT;
                     cnt      <= '0;
                     mem_req  <= 1'b1;
                     mem_addr <= aligned_addr;
                  end
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  state      <= RESP;
                  cnt        <= '0;
                  mem_req    <= 1'b0;
                  mem_addr   <= '0;
                  resp_valid <= 1'b1;
                  resp_data  <= extracted;
                  resp_exc   <= EXC_NONE;
               end else if (cnt == CNT_LAST) begin
                  state      <= RESP;
                  cnt        <= '0;
                  mem_req    <= 1'b0;
                  mem_addr   <= '0;
                  resp_valid <= 1'b1;
                  resp_data  <= '0;
                  resp_exc   <= EXC_DBE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
                  resp_data  <= '0;
                  resp_exc   <= EXC_NONE;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
